wbdpbram_reader: RTL and testbench



---
 rtl/wbdpbram_reader.sv | 181 ++++++++++++++++++
 tb/tb_wbdpbram_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wbdpbram_reader.sv
`default_nettype none
// ============================================================================
// Module   : wbdpbram_reader
// Purpose  : Streaming read engine for port B of the dual-port block RAM.
//            On i_start it reads i_len consecutive words starting at i_base.
//            The address wraps modulo 1<<ADDR_WIDTH. The words are presented
//            on a valid/ready stream at up to one word per cycle.
//            A 2-entry output FIFO absorbs the one-cycle BRAM read latency
//            under backpressure.
// Ports    : i_clk, i_rst_n (sync, active-low)
//            i_start / i_base / i_len : command (accepted only when idle)
//            o_busy, o_done           : status (o_done is a 1-cycle pulse)
//            o_enB / o_addrB / i_doutB: BRAM port B (registered read)
//            o_valid / o_data / o_last / i_ready : output stream
// Options  : WBDPBRAM_READER_ABORT_EN adds input i_abort. When i_abort is high
//            in a busy state, the transfer is cancelled and o_done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module wbdpbram_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [ADDR_WIDTH:0]   i_len,
`ifdef WBDPBRAM_READER_ABORT_EN
    input  logic                  i_abort,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_enB,
    output logic [ADDR_WIDTH-1:0] o_addrB,
    input  logic [DATA_WIDTH-1:0] i_doutB,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    input  logic                  i_ready
);

    localparam logic [ADDR_WIDTH:0]   c_REMAIN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_REMAIN_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_done_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remain;
    logic                  r_inflight;       // read issued last cycle, data on i_doutB now
    logic                  r_inflight_last;  // that read was the final word
    logic                  r_done;

    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic [1:0]            r_fifo_last;
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;

    logic                  w_pop;
    logic                  w_issue;
    logic                  w_abort;
    logic [1:0]            w_count_next;

`ifdef WBDPBRAM_READER_ABORT_EN
    assign w_abort = i_abort && (r_state != ST_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign o_valid = (r_count != 2'd0);
    assign w_pop   = o_valid && i_ready;

    // The issue rule counts the buffered words, plus the word in flight, minus
    // the word leaving this cycle. This keeps the buffer at two words or fewer,
    // yet still allows one read per cycle when the stream drains every cycle.
    assign w_issue = (r_state == ST_READ) && (r_remain != c_REMAIN_ZERO) && !w_abort &&
                     (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

    assign w_count_next = r_count + {1'b0, r_inflight} - {1'b0, w_pop};

    assign o_enB   = w_issue;
    assign o_addrB = w_issue ? r_addr : '0;
    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = r_done;
    assign o_data  = o_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign o_last  = o_valid && r_fifo_last[r_rd_ptr];

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_len != c_REMAIN_ZERO) begin
                        w_state_next = ST_READ;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (w_issue && (r_remain == c_REMAIN_ONE)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave when the last word is accepted this cycle. The done
                // pulse then lines up with the first idle cycle.
                if (!r_inflight && (w_count_next == 2'd0)) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_done          <= 1'b0;
            r_addr          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_data[0]  <= '0;
            r_fifo_data[1]  <= '0;
            r_fifo_last     <= 2'b00;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;

            if ((r_state == ST_IDLE) && i_start && (i_len != c_REMAIN_ZERO)) begin
                r_addr   <= i_base;
                r_remain <= i_len;
            end else if (w_issue) begin
                r_addr   <= r_addr + c_ADDR_ONE;
                r_remain <= r_remain - c_REMAIN_ONE;
            end

            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remain == c_REMAIN_ONE);

            if (w_abort) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (r_inflight) begin
                    r_fifo_data[r_wr_ptr] <= i_doutB;
                    r_fifo_last[r_wr_ptr] <= r_inflight_last;
                    r_wr_ptr              <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= w_count_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wbdpbram_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbdpbram_reader
// Purpose  : Self-checking bench for wbdpbram_reader. A behavioural BRAM feeds
//            the DUT. For every transfer, a reference stream is derived from
//            the memory array as mem[(base+k) % DEPTH]. That stream is
//            compared with the DUT's handshaken output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wbdpbram_reader;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base  = '0;
    logic [AW:0]   len   = '0;
    logic          ready = 1'b0;
    logic          busy, done, enB, valid, last;
    logic [AW-1:0] addrB;
    logic [DW-1:0] doutB = '0;
    logic [DW-1:0] data;
`ifdef WBDPBRAM_READER_ABORT_EN
    logic          abort = 1'b0;
`endif

    wbdpbram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_base  (base),
        .i_len   (len),
`ifdef WBDPBRAM_READER_ABORT_EN
        .i_abort (abort),
`endif
        .o_busy  (busy),
        .o_done  (done),
        .o_enB   (enB),
        .o_addrB (addrB),
        .i_doutB (doutB),
        .o_valid (valid),
        .o_data  (data),
        .o_last  (last),
        .i_ready (ready)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: one-cycle registered read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (enB) doutB <= mem[addrB];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state for the current transfer.
    bit            active     = 1'b0;
    int            exp_base   = 0;
    int            exp_len    = 0;
    int            iss        = 0;
    int            pop        = 0;
    int            ready_mode = 0;
    int            ph         = 0;
    logic [DW-1:0] first_data = '0;
    logic [DW-1:0] last_data  = '0;

    // Count issues and accepted words at each edge; check issue addresses.
    always @(posedge clk) begin
        if (active) begin
            if (enB) begin
                chk("issue_addr", addrB, (exp_base + iss) % DEPTH);
                chk("issue_in_range", iss < exp_len, 1);
                iss++;
            end
            if (valid && ready) begin
                if (pop == 0) first_data = data;
                if (pop == exp_len - 1) last_data = data;
                pop++;
            end
        end
    end

    // The head of the stream must always be the next unaccepted reference word.
    always @(negedge clk) begin
        if (active) begin
            if (valid) begin
                chk("stream_data", data, mem[(exp_base + pop) % DEPTH]);
                chk("stream_last", last, pop == exp_len - 1);
                chk("stream_in_range", pop < exp_len, 1);
            end
            chk("buffered_le_2", (iss - pop) <= 2, 1);
            if (!enB) chk("addr_zero_when_idle", addrB, 0);
        end
    end

    // Ready driver: 0 = always high, 1 = random, 2 = pattern 1,0,0.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ph++;
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = ($urandom_range(0, 1) != 0);
                default: ready = (ph % 3 == 0);
            endcase
        end
    end

    task automatic launch(input int b, input int l, input int mode);
        exp_base   = b;
        exp_len    = l;
        iss        = 0;
        pop        = 0;
        ready_mode = mode;
        @(posedge clk);
        #1;
        active = 1'b1;
        start  = 1'b1;
        base   = AW'(b);
        len    = (AW + 1)'(l);
        @(posedge clk);            // edge E0
        #1;
        start  = 1'b0;
        base   = AW'($urandom);
        len    = (AW + 1)'($urandom);
    endtask

    task automatic run(input int b, input int l, input int mode, input bit lat);
        int n;
        int fv;
        launch(b, l, mode);
        n  = 0;
        fv = 0;
        forever begin
            @(negedge clk);
            n++;
            if (valid && fv == 0) fv = n;
            if (done) break;
            if (n > 4000) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
        active = 1'b0;
        chk("busy_low_at_done", busy, 0);
        chk("words_delivered", pop, l);
        chk("words_issued", iss, l);
        if (lat) begin
            chk("done_cycle", n, (l == 0) ? 1 : l + 3);
            if (l > 0) chk("first_valid_cycle", fv, 3);
        end
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 32'h100);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {busy, done, enB, valid, last}, 0);
        chk("reset_addr", addrB, 0);
        chk("reset_data", data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run(4, 8, 0, 1);
        chk("lit_first_0x104", first_data, 32'h104);
        chk("lit_last_0x10B", last_data, 32'h10B);

        run(1022, 4, 0, 1);
        chk("lit_wrap_first", first_data, 32'h4FE);
        chk("lit_wrap_last", last_data, 32'h101);

        run(10, 5, 2, 0);
        run(7, 0, 0, 1);
        run(300, 1024, 0, 1);

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int k = 0; k < 12; k++) run($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), 1, 0);
        run($urandom_range(0, DEPTH - 1), 1, 2, 0);

        // Reset in cycle 4 of a len=8 transfer.
        launch(4, 8, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 active = 1'b0;
        @(negedge clk);
        chk("midreset_ctrl", {busy, done, enB, valid, last}, 0);
        chk("midreset_addr", addrB, 0);
        chk("midreset_data", data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_reset", done, 0);
        end
        run(200, 6, 1, 0);

`ifdef WBDPBRAM_READER_ABORT_EN
        launch(50, 8, 0);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort  = 1'b0;
        active = 1'b0;
        @(negedge clk);
        chk("abort_valid_low", valid, 0);
        chk("abort_done", done, 1);
        chk("abort_busy_low", busy, 0);
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_enB", enB, 0);
            chk("abort_no_valid", valid, 0);
            chk("abort_done_once", done, 0);
        end
        run(60, 3, 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
